// File: rtl/phy_mem_responder.sv
// Single-clock memory responder: queued 512-bit requests served strictly in order,
// writes applied at dequeue, reads answered after a fixed latency and held until granted.
package ShellTypes;
  typedef struct packed {
    logic         valid;
    logic         isWrite;
    logic [31:0]  addr;
    logic [511:0] data;
  } MemReq;

  typedef struct packed {
    logic         valid;
    logic [511:0] data;
  } MemResp;
endpackage

module phy_mem_responder
  import ShellTypes::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 8,
  parameter int QDEPTH    = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  MemReq  mem_req,
  output logic   mem_req_grant,
  output MemResp mem_resp,
  input  logic   mem_resp_grant
);
  localparam int PW = $clog2(QDEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  logic [511:0]         r_mem    [2**ADDR_BITS];
  logic                 r_q_wr   [QDEPTH];
  logic [ADDR_BITS-1:0] r_q_addr [QDEPTH];
  logic [511:0]         r_q_data [QDEPTH];

  logic [PW-1:0]        r_wp;
  logic [PW-1:0]        r_rp;
  logic [PW:0]          r_count;
  state_t               r_state;
  logic [7:0]           r_cnt;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_grant;
  logic                 r_armed;
  logic                 r_resp_valid;
  logic [511:0]         r_resp_data;

  logic w_capture;
  logic w_pop;
  logic w_unused_addr;

  // r_armed stays low through reset and the first edge after it, blocking capture there
  assign w_capture     = mem_req.valid && !r_grant && r_armed && (r_count < (PW+1)'(QDEPTH));
  assign w_pop         = (r_state == S_IDLE) && (r_count != '0);
  assign w_unused_addr = ^mem_req.addr[31:ADDR_BITS];

  // Queue payload and backing store carry no reset; store contents survive rst
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_q_wr[r_wp]   <= mem_req.isWrite;
      r_q_addr[r_wp] <= mem_req.addr[ADDR_BITS-1:0];
      r_q_data[r_wp] <= mem_req.data;
    end
    if (w_pop && r_q_wr[r_rp])
      r_mem[r_q_addr[r_rp]] <= r_q_data[r_rp];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wp         <= '0;
      r_rp         <= '0;
      r_count      <= '0;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_grant      <= 1'b0;
      r_armed      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_armed <= 1'b1;
      r_grant <= w_capture;
      if (w_capture) r_wp <= r_wp + PW'(1);
      if (w_pop)     r_rp <= r_rp + PW'(1);
      if (w_capture && !w_pop)
        r_count <= r_count + (PW+1)'(1);
      else if (!w_capture && w_pop)
        r_count <= r_count - (PW+1)'(1);

      case (r_state)
        S_IDLE: begin
          if (w_pop && !r_q_wr[r_rp]) begin
            r_addr  <= r_q_addr[r_rp];
            r_cnt   <= 8'(LATENCY);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_data  <= r_mem[r_addr];
          end
        end
        S_RESP: begin
          if (mem_resp_grant) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req_grant = r_grant;
  assign mem_resp.valid = r_resp_valid;
  assign mem_resp.data  = r_resp_data;

endmodule

// File: tb/tb_phy_mem_responder.sv
// Self-checking bench for phy_mem_responder: directed scenarios plus a randomized
// request stream compared against an in-order memory model with address aliasing.
module tb_phy_mem_responder;
  import ShellTypes::*;

  logic   clk = 1'b0;
  logic   rst;
  MemReq  req0, req1;
  MemResp resp0, resp1;
  logic   gnt0, gnt1, rg0, rg1;

  int n_vec = 0;
  int n_err = 0;

  logic [511:0] model [int];
  logic [511:0] expq [$];

  phy_mem_responder #(.ADDR_BITS(10), .LATENCY(8), .QDEPTH(4)) dut (
    .clk(clk), .rst(rst), .mem_req(req0), .mem_req_grant(gnt0),
    .mem_resp(resp0), .mem_resp_grant(rg0));

  phy_mem_responder #(.ADDR_BITS(10), .LATENCY(1), .QDEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .mem_req(req1), .mem_req_grant(gnt1),
    .mem_resp(resp1), .mem_resp_grant(rg1));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached, required completion earlier");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int key(input logic [31:0] a);
    return int'(a[9:0]);
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int unsigned i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Presents one request and waits (bounded) for its grant; the model is updated in
  // arrival order, which is also service order.
  task automatic issue(input bit d1, input bit wr, input logic [31:0] a, input logic [511:0] d);
    MemReq r;
    bit got;
    got = 1'b0;
    r = '0;
    r.valid = 1'b1;
    r.isWrite = wr;
    r.addr = a;
    r.data = d;
    if (d1) req1 = r; else req0 = r;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      got = d1 ? gnt1 : gnt0;
    end
    if (d1) req1.valid = 1'b0; else req0.valid = 1'b0;
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL issue_grant addr=%h: no grant seen, required a grant within 300 cycles", a);
    end else if (!d1) begin
      if (wr) model[key(a)] = d;
      else expq.push_back(model.exists(key(a)) ? model[key(a)] : 'x);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0 = '0; req1 = '0; rg0 = 1'b0; rg1 = 1'b0;
    tick(); tick();
    n_vec++;
    if (gnt0 !== 1'b0 || resp0.valid !== 1'b0 || resp0.data !== '0) begin
      n_err++;
      $display("FAIL reset_dut grant=%b valid=%b data=%h, required 0/0/0", gnt0, resp0.valid, resp0.data[63:0]);
    end
    n_vec++;
    if (gnt1 !== 1'b0 || resp1.valid !== 1'b0 || resp1.data !== '0) begin
      n_err++;
      $display("FAIL reset_dut1 grant=%b valid=%b data=%h, required 0/0/0", gnt1, resp1.valid, resp1.data[63:0]);
    end
    #3 rst = 1'b0;
    tick(); tick();
    n_vec++;
    if (gnt0 !== 1'b0 || resp0.valid !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle grant=%b valid=%b, required 0/0", gnt0, resp0.valid);
    end
  endtask

  task automatic test_write_read();
    int lat;
    logic [511:0] exp_d;
    bit stray;
    issue(0, 1'b1, 32'h898, 512'h42);
    tick();
    n_vec++;
    if (gnt0 !== 1'b0) begin
      n_err++;
      $display("FAIL grant_pulse grant=%b one cycle after grant, required 0", gnt0);
    end
    issue(0, 1'b0, 32'h898, '0);
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      tick();
      if (resp0.valid) lat = i;
    end
    // capture edge -> pop at next edge -> valid LATENCY edges later
    n_vec++;
    if (lat != 9) begin
      n_err++;
      $display("FAIL read_latency edges=%0d after capture, required 9", lat);
    end
    exp_d = expq.pop_front();
    n_vec++;
    if (resp0.data !== exp_d) begin
      n_err++;
      $display("FAIL read_data data=%h, required %h", resp0.data[63:0], exp_d[63:0]);
    end
    rg0 = 1'b1; tick(); rg0 = 1'b0;
    n_vec++;
    if (resp0.valid !== 1'b0) begin
      n_err++;
      $display("FAIL resp_drop valid=%b after grant, required 0", resp0.valid);
    end
    stray = 1'b0;
    repeat (15) begin tick(); if (resp0.valid) stray = 1'b1; end
    n_vec++;
    if (stray) begin
      n_err++;
      $display("FAIL no_extra_resp valid seen=1, required no further response");
    end
  endtask

  task automatic test_alias();
    issue(0, 1'b1, 32'h0042_0003, 512'h98);
    issue(0, 1'b0, 32'h0042_0003, '0);
    issue(0, 1'b0, 32'h0000_0003, '0);
    for (int k = 0; k < 2; k++) begin
      logic [511:0] exp_d;
      for (int i = 0; i < 50 && !resp0.valid; i++) tick();
      exp_d = (expq.size() != 0) ? expq.pop_front() : 'x;
      n_vec++;
      if (resp0.valid !== 1'b1 || resp0.data !== exp_d) begin
        n_err++;
        $display("FAIL alias_resp%0d valid=%b data=%h, required 1/%h", k, resp0.valid, resp0.data[63:0], exp_d[63:0]);
      end
      rg0 = 1'b1; tick(); rg0 = 1'b0;
      n_vec++;
      if (resp0.valid !== 1'b0) begin
        n_err++;
        $display("FAIL alias_drop%0d valid=%b, required 0", k, resp0.valid);
      end
    end
  endtask

  task automatic test_withhold();
    logic [511:0] exp_d;
    issue(0, 1'b1, 32'h2A5, rand512());
    issue(0, 1'b0, 32'h2A5, '0);
    for (int i = 0; i < 40 && !resp0.valid; i++) tick();
    exp_d = expq.pop_front();
    for (int i = 0; i < 20; i++) begin
      n_vec++;
      if (resp0.valid !== 1'b1 || resp0.data !== exp_d) begin
        n_err++;
        $display("FAIL withhold_c%0d valid=%b data=%h, required 1/%h", i, resp0.valid, resp0.data[63:0], exp_d[63:0]);
      end
      tick();
    end
    rg0 = 1'b1; tick(); rg0 = 1'b0;
    n_vec++;
    if (resp0.valid !== 1'b0) begin
      n_err++;
      $display("FAIL withhold_drop valid=%b, required 0", resp0.valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] exp_d;
    logic [31:0]  a5;
    int e;
    for (int k = 0; k < 6; k++) issue(0, 1'b1, 32'h100 + k, rand512());
    issue(0, 1'b0, 32'h100, '0);
    for (int i = 0; i < 40 && !resp0.valid; i++) tick();
    exp_d = expq.pop_front();
    n_vec++;
    if (resp0.valid !== 1'b1 || resp0.data !== exp_d) begin
      n_err++;
      $display("FAIL b2b_first valid=%b data=%h, required 1/%h", resp0.valid, resp0.data[63:0], exp_d[63:0]);
    end
    // response held ungranted; four reads fill the queue, the fifth must wait
    for (int k = 1; k <= 4; k++) issue(0, 1'b0, 32'h100 + k, '0);
    a5 = 32'h105;
    req0 = '0;
    req0.valid = 1'b1;
    req0.addr = a5;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_vec++;
      if (gnt0 !== 1'b0 || resp0.valid !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_full_c%0d grant=%b valid=%b, required 0/1", i, gnt0, resp0.valid);
      end
    end
    rg0 = 1'b1;
    e = 0;
    for (int i = 1; i <= 20 && e == 0; i++) begin
      tick();
      rg0 = 1'b0;
      if (gnt0) e = i;
    end
    req0.valid = 1'b0;
    expq.push_back(model[key(a5)]);
    n_vec++;
    if (e != 3) begin
      n_err++;
      $display("FAIL b2b_fifth_grant edges=%0d after response grant, required 3", e);
    end
    for (int k = 1; k <= 5; k++) begin
      for (int i = 0; i < 60 && !resp0.valid; i++) tick();
      exp_d = (expq.size() != 0) ? expq.pop_front() : 'x;
      n_vec++;
      if (resp0.valid !== 1'b1 || resp0.data !== exp_d) begin
        n_err++;
        $display("FAIL b2b_resp%0d valid=%b data=%h, required 1/%h", k, resp0.valid, resp0.data[63:0], exp_d[63:0]);
      end
      rg0 = 1'b1; tick(); rg0 = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [511:0] d;
    int lat;
    bit stray;
    d = rand512();
    issue(0, 1'b1, 32'h0AA, d);
    issue(0, 1'b0, 32'h0AA, '0);
    issue(0, 1'b0, 32'h0AB, '0);
    issue(0, 1'b0, 32'h0AC, '0);
    expq.delete();
    #2 rst = 1'b1;
    #2;
    n_vec++;
    if (gnt0 !== 1'b0 || resp0.valid !== 1'b0 || resp0.data !== '0) begin
      n_err++;
      $display("FAIL rst_async grant=%b valid=%b data=%h, required 0/0/0", gnt0, resp0.valid, resp0.data[63:0]);
    end
    req0 = '0;
    req0.valid = 1'b1;
    req0.addr = 32'h0AA;
    #3 rst = 1'b0;
    tick();
    n_vec++;
    if (gnt0 !== 1'b0) begin
      n_err++;
      $display("FAIL rst_first_edge grant=%b, required 0", gnt0);
    end
    tick();
    n_vec++;
    if (gnt0 !== 1'b1) begin
      n_err++;
      $display("FAIL rst_second_edge grant=%b, required 1", gnt0);
    end
    req0.valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      tick();
      if (resp0.valid) lat = i;
    end
    n_vec++;
    if (lat != 9 || resp0.data !== d) begin
      n_err++;
      $display("FAIL rst_readback edges=%0d data=%h, required 9/%h", lat, resp0.data[63:0], d[63:0]);
    end
    rg0 = 1'b1; tick(); rg0 = 1'b0;
    stray = 1'b0;
    repeat (30) begin tick(); if (resp0.valid) stray = 1'b1; end
    n_vec++;
    if (stray) begin
      n_err++;
      $display("FAIL rst_discard stale response valid=1, required none");
    end
  endtask

  task automatic test_latency1();
    int lat;
    issue(1, 1'b1, 32'h154, 512'h1234);
    issue(1, 1'b0, 32'h154, '0);
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      tick();
      if (resp1.valid) lat = i;
    end
    n_vec++;
    if (lat != 2 || resp1.data !== 512'h1234) begin
      n_err++;
      $display("FAIL lat1_read edges=%0d data=%h, required 2/1234", lat, resp1.data[63:0]);
    end
    rg1 = 1'b1; tick(); rg1 = 1'b0;
    n_vec++;
    if (resp1.valid !== 1'b0) begin
      n_err++;
      $display("FAIL lat1_drop valid=%b, required 0", resp1.valid);
    end
  endtask

  task automatic test_random();
    logic [31:0]  pool [6];
    bit           op_wr [48];
    logic [31:0]  op_a  [48];
    logic [511:0] op_d  [48];
    int nrd;
    nrd = 0;
    for (int i = 0; i < 6; i++) pool[i] = 32'($urandom_range(0, 1023));
    for (int i = 0; i < 48; i++) begin
      op_wr[i] = (i < 6) ? 1'b1 : 1'($urandom_range(0, 1));
      op_a[i]  = (i < 6) ? pool[i] : pool[$urandom_range(0, 5)];
      op_a[i][31:10] = 22'($urandom);
      op_d[i]  = rand512();
      if (!op_wr[i]) nrd++;
    end
    fork
      begin
        for (int i = 0; i < 48; i++) begin
          issue(0, op_wr[i], op_a[i], op_d[i]);
          repeat ($urandom_range(0, 2)) tick();
        end
      end
      begin
        for (int k = 0; k < nrd; k++) begin
          logic [511:0] exp_d;
          logic [511:0] held;
          for (int i = 0; i < 400 && !resp0.valid; i++) tick();
          exp_d = (expq.size() != 0) ? expq.pop_front() : 'x;
          n_vec++;
          if (resp0.valid !== 1'b1 || resp0.data !== exp_d) begin
            n_err++;
            $display("FAIL rand_resp%0d valid=%b data=%h, required 1/%h", k, resp0.valid, resp0.data[63:0], exp_d[63:0]);
          end
          held = resp0.data;
          repeat ($urandom_range(0, 3)) begin
            tick();
            n_vec++;
            if (resp0.valid !== 1'b1 || resp0.data !== held) begin
              n_err++;
              $display("FAIL rand_hold%0d valid=%b data=%h, required 1/%h", k, resp0.valid, resp0.data[63:0], held[63:0]);
            end
          end
          rg0 = 1'b1; tick(); rg0 = 1'b0;
          n_vec++;
          if (resp0.valid !== 1'b0) begin
            n_err++;
            $display("FAIL rand_drop%0d valid=%b, required 0", k, resp0.valid);
          end
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alias();
    test_withhold();
    test_back_to_back();
    test_reset_mid();
    test_latency1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/phy_mem_responder.md
PHY_MEM_RESPONDER -- requirements
Module: phy_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10: number of 512-bit words in the backing store is 2**ADDR_BITS.
REQ-002 SHALL have parameter LATENCY, default 8: cycles from read dequeue to response valid; legal range 1..255.
REQ-003 SHALL have parameter QDEPTH, default 4: request queue entries; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port mem_req, input, MemReq from ShellTypes (valid, isWrite, addr[31:0], data[511:0]): physical memory request.
REQ-007 SHALL have port mem_req_grant, output, 1 bit: one-cycle pulse acknowledging capture of mem_req.
REQ-008 SHALL have port mem_resp, output, MemResp from ShellTypes (valid, data[511:0]): read response.
REQ-009 SHALL have port mem_resp_grant, input, 1 bit: requester has consumed mem_resp.

Function
REQ-010 SHALL capture mem_req into the queue at a rising edge when mem_req.valid=1, mem_req_grant=0 and queue occupancy < QDEPTH.
REQ-011 SHALL drive mem_req_grant=1 for exactly the one cycle following a capture, and 0 otherwise; the forced-low cycle prevents double capture while the requester drops valid.
REQ-012 SHALL hold off the grant with the queue full; the request stays pending and is captured at the first edge a slot is free.
REQ-013 SHALL index the store with addr[ADDR_BITS-1:0]; upper address bits SHALL be ignored, so addresses alias.
REQ-014 SHALL service requests strictly in arrival order via FSM states IDLE, WAIT and RESP.
REQ-015 SHALL, in IDLE with the queue non-empty, pop the head at the next edge; a write pops, updates the store at that edge and stays in IDLE; a read pops, loads the counter with LATENCY and enters WAIT.
REQ-016 SHALL decrement the counter each edge in WAIT; at the edge where counter=1, it SHALL enter RESP with mem_resp.data registered from the store at the popped address.
REQ-017 SHALL make mem_resp.valid high in the cycle starting LATENCY edges after the pop edge.
REQ-018 SHALL hold mem_resp.valid=1 and mem_resp.data stable in RESP until an edge with mem_resp_grant=1, then return to IDLE.
REQ-019 SHALL make mem_resp.valid low in the cycle after that grant; a further pop SHALL occur no earlier than the edge after the return to IDLE.
REQ-020 SHALL ignore mem_resp_grant outside RESP.
REQ-021 SHALL generate no response for a write; the write is acknowledged by mem_req_grant only.
REQ-022 SHALL allow enqueue and dequeue at the same edge, leaving occupancy unchanged; a request arriving at a full queue during a pop edge is captured at the following edge.
REQ-023 SHALL return to a read the value of every earlier-queued write to the same word, since writes apply at pop and reads sample after.
REQ-024 SHALL use wrap-around queue pointers and a count field of log2(QDEPTH)+1 bits.
REQ-025 SHALL keep the counter at 8 bits.

Reset
REQ-026 SHALL, while rst=1 (asynchronously), force: FSM=IDLE, queue empty, counter=0, mem_req_grant=0, mem_resp.valid=0, mem_resp.data=0.
REQ-027 SHALL leave store contents unchanged by reset.
REQ-028 SHALL, on reset mid-operation, discard all pending and in-flight requests with no response and no late grant.
REQ-029 SHALL, in the first edge after rst deasserts, neither capture nor grant a request.

Verification
REQ-030 SHALL cover: write addr 0x898 data 0x42, then read 0x898 -> grant pulse each, one response data=0x42, valid rises 8 edges after the read pop.
REQ-031 SHALL cover: write 0x00420003 data 0x98, then read 0x00420003 and 0x00000003 (aliased) -> two responses, both data=0x98, in order.
REQ-032 SHALL cover: 5 back-to-back reads with mem_resp_grant held 0 -> 4 grants; 5th grant only after the first response is granted and popped.
REQ-033 SHALL cover: mem_resp_grant withheld 20 cycles -> valid and data stable for all 20 cycles; valid low in the cycle after the grant.
REQ-034 SHALL cover: rst pulsed mid-WAIT with 2 reads queued -> valid stays 0, queue empty, prior write data still readable after reset.
REQ-035 SHALL cover: LATENCY=1 build, read 0x154 after write 0x1234 -> valid in the cycle after the pop, data=0x1234.
